// File: rtl/flag_ckpt_reg.sv
// Purpose : condition-flag register with per-bit write mask, same-cycle forwarding and a LIFO checkpoint stack.
// Latency : writes, pushes and pops take effect on the next rising edge; fwd_flags is combinational.
// Backpressure: none; a push while full or a pop while empty is dropped and raises a sticky error bit.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   wr_en/wr_mask/in_flags  masked flag write request
//   push/pop              save current flags to / restore flags from the checkpoint stack
//   clr_err               clear sticky err_ovf/err_udf
//   out_flags             registered flag state
//   fwd_flags             merged write value when writing without a pop, else out_flags
//   depth/full/empty      stack occupancy decodes of registered state
//   err_ovf/err_udf       sticky overflow / underflow indications
module flag_ckpt_reg #(
    parameter int                    NUM_FLAGS = 4,
    parameter int                    DEPTH     = 4,
    parameter logic [NUM_FLAGS-1:0]  RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [NUM_FLAGS-1:0]          wr_mask,
    input  logic [NUM_FLAGS-1:0]          in_flags,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clr_err,
    output logic [NUM_FLAGS-1:0]          out_flags,
    output logic [NUM_FLAGS-1:0]          fwd_flags,
    output logic [$clog2(DEPTH+1)-1:0]    depth,
    output logic                          full,
    output logic                          empty,
    output logic                          err_ovf,
    output logic                          err_udf
);

    localparam int DW = $clog2(DEPTH + 1);

    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_udf_q, err_udf_d;
    logic [NUM_FLAGS-1:0] stack_q [DEPTH];

    logic                 full_w, empty_w;
    logic                 push_only, pop_only;
    logic                 do_push, do_pop;
    logic [NUM_FLAGS-1:0] merged;
    logic [NUM_FLAGS-1:0] top;

    always_comb begin
        full_w    = (depth_q == DW'(DEPTH));
        empty_w   = (depth_q == '0);
        // Simultaneous push and pop cancel: no stack movement, no error.
        push_only = push & ~pop;
        pop_only  = pop & ~push;
        do_push   = push_only & ~full_w;
        do_pop    = pop_only & ~empty_w;

        merged = (flags_q & ~wr_mask) | (in_flags & wr_mask);

        // Decode-select the top entry to keep index widths independent of DEPTH.
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top = stack_q[i];
            end
        end

        // A successful pop overrides any write; a failed pop lets the write through.
        flags_d = flags_q;
        if (do_pop) begin
            flags_d = top;
        end else if (wr_en) begin
            flags_d = merged;
        end

        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end

        // New error wins over a same-cycle clear.
        err_ovf_d = (push_only & full_w)  | (err_ovf_q & ~clr_err);
        err_udf_d = (pop_only  & empty_w) | (err_udf_q & ~clr_err);

        fwd_flags = (wr_en & ~pop) ? merged : flags_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= RESET_VAL;
            depth_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q   <= flags_d;
            depth_q   <= depth_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
            // Checkpoint captures the pre-write flags.
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (depth_q == DW'(i))) begin
                    stack_q[i] <= flags_q;
                end
            end
        end
    end

    assign out_flags = flags_q;
    assign depth     = depth_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_flag_ckpt_reg.sv
// Purpose : self-checking bench for flag_ckpt_reg (directed table, random vs. reference model, async reset).
// Latency : drives inputs 1 time unit after a rising edge, samples fwd_flags before the edge and state after it.
// Backpressure: not applicable.
module tb_flag_ckpt_reg;

    localparam int NF = 4;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [NF-1:0] wr_mask;
    logic [NF-1:0] in_flags;
    logic          push;
    logic          pop;
    logic          clr_err;
    logic [NF-1:0] out_flags;
    logic [NF-1:0] fwd_flags;
    logic [2:0]    depth;
    logic          full;
    logic          empty;
    logic          err_ovf;
    logic          err_udf;

    flag_ckpt_reg #(
        .NUM_FLAGS (NF),
        .DEPTH     (DP),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_mask   (wr_mask),
        .in_flags  (in_flags),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .out_flags (out_flags),
        .fwd_flags (fwd_flags),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags as a plain value, checkpoints as a queue used as a stack.
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stk[$];
    logic          m_ovf, m_udf;
    logic [NF-1:0] m_fwd;

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step();
        logic [NF-1:0] wval;
        logic          popped, new_ovf, new_udf;
        logic [NF-1:0] pval;
        wval    = (m_flags & ~wr_mask) | (in_flags & wr_mask);
        m_fwd   = (wr_en && !pop) ? wval : m_flags;
        popped  = 1'b0;
        pval    = '0;
        new_ovf = 1'b0;
        new_udf = 1'b0;
        if (push && !pop) begin
            if (m_stk.size() == DP) new_ovf = 1'b1;
            else m_stk.push_back(m_flags);
        end
        if (pop && !push) begin
            if (m_stk.size() == 0) new_udf = 1'b1;
            else begin
                pval   = m_stk.pop_back();
                popped = 1'b1;
            end
        end
        if (popped) m_flags = pval;
        else if (wr_en) m_flags = wval;
        m_ovf = new_ovf | (m_ovf & !clr_err);
        m_udf = new_udf | (m_udf & !clr_err);
    endtask

    logic [NF-1:0] fwd_seen;

    // Apply one cycle of inputs; captures fwd_flags before the edge and leaves time at edge+1.
    task automatic drive(input logic we, input logic [NF-1:0] m, input logic [NF-1:0] in,
                         input logic pu, input logic po, input logic cl);
        wr_en = we; wr_mask = m; in_flags = in; push = pu; pop = po; clr_err = cl;
        #1;
        fwd_seen = fwd_flags;
        model_step();
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_mask = '0; in_flags = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".fwd"},   32'(fwd_seen),  32'(m_fwd));
        check({tag, ".out"},   32'(out_flags), 32'(m_flags));
        check({tag, ".depth"}, 32'(depth),     32'(m_stk.size()));
        check({tag, ".full"},  32'(full),      32'(m_stk.size() == DP));
        check({tag, ".empty"}, 32'(empty),     32'(m_stk.size() == 0));
        check({tag, ".ovf"},   32'(err_ovf),   32'(m_ovf));
        check({tag, ".udf"},   32'(err_udf),   32'(m_udf));
    endtask

    typedef struct {
        logic          we;
        logic [NF-1:0] m;
        logic [NF-1:0] in;
        logic          pu;
        logic          po;
        logic          cl;
        logic [NF-1:0] e_fwd;
        logic [NF-1:0] e_out;
        logic [2:0]    e_dep;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        //           we  mask     in       pu   po   cl   fwd      out      dep   ovf  udf
        tbl[0]  = '{1'b1, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b1001, 1'b1, 1'b0, 1'b0, 4'b1001, 4'b1001, 3'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b0110, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1111, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd4, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0100, 3'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0010, 3'd1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0001, 3'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0011, 3'd0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0011, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 3'd1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 3'd2, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0011, 4'b0011, 3'd2, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0011, 4'b0010, 3'd2, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd3, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd4, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'd4, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 3'd4, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010, 3'd4, 1'b0, 1'b0};
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_mask = '0; in_flags = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        model_reset();
        #8;
        check("rst.out",   32'(out_flags), 32'h0);
        check("rst.depth", 32'(depth),     32'h0);
        check("rst.empty", 32'(empty),     32'h1);
        check("rst.full",  32'(full),      32'h0);
        check("rst.ovf",   32'(err_ovf),   32'h0);
        check("rst.udf",   32'(err_udf),   32'h0);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].we, tbl[i].m, tbl[i].in, tbl[i].pu, tbl[i].po, tbl[i].cl);
            check($sformatf("vec%0d.fwd", i),   32'(fwd_seen),  32'(tbl[i].e_fwd));
            check($sformatf("vec%0d.out", i),   32'(out_flags), 32'(tbl[i].e_out));
            check($sformatf("vec%0d.depth", i), 32'(depth),     32'(tbl[i].e_dep));
            check($sformatf("vec%0d.full", i),  32'(full),      32'(tbl[i].e_dep == 3'd4));
            check($sformatf("vec%0d.empty", i), 32'(empty),     32'(tbl[i].e_dep == 3'd0));
            check($sformatf("vec%0d.ovf", i),   32'(err_ovf),   32'(tbl[i].e_ovf));
            check($sformatf("vec%0d.udf", i),   32'(err_udf),   32'(tbl[i].e_udf));
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0));
            check_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset in the middle of a cycle with depth=3 and err_ovf set.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        drive(1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1010, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1100, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("pre_arst.depth", 32'(depth),   32'd3);
        check("pre_arst.ovf",   32'(err_ovf), 32'd1);
        check("pre_arst.out",   32'(out_flags), 32'(4'b1100));
        #2 reset = 1'b1;
        #1;
        check("arst.out",   32'(out_flags), 32'h0);
        check("arst.depth", 32'(depth),     32'h0);
        check("arst.empty", 32'(empty),     32'h1);
        check("arst.full",  32'(full),      32'h0);
        check("arst.ovf",   32'(err_ovf),   32'h0);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("post_arst.udf",   32'(err_udf), 32'd1);
        check("post_arst.depth", 32'(depth),   32'd0);
        check_model("post_arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_ckpt_reg.md
Name: flag_ckpt_reg

Overview:
- Parametrised condition-flag register (default N,Z,V,C) with per-bit write mask, same-cycle forwarding output and a LIFO checkpoint stack for saving/restoring flags.
- Sits beside the ALU/flag-setting datapath of the pipelined CPU: the execute stage writes flags, branch/conditional logic reads them.
- Checkpoints are pushed on speculation or exception entry and popped on recovery or return.

Parameters:
- NUM_FLAGS, 4, flag vector width; bit order {N,Z,V,C} = [3:0] at default.
- DEPTH, 4, checkpoint stack entries; must be >=1.
- RESET_VAL, '0 (NUM_FLAGS bits), flag value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  flag write request this cycle.
- wr_mask  input  NUM_FLAGS  per-bit write enable; only bits with mask=1 update.
- in_flags  input  NUM_FLAGS  new flag values.
- push  input  1  save current stored flags onto the stack.
- pop  input  1  restore flags from the top of the stack.
- clr_err  input  1  clear sticky error bits.
- out_flags  output  NUM_FLAGS  registered flag state.
- fwd_flags  output  NUM_FLAGS  combinational view: merged write value when wr_en=1 and pop=0, else out_flags.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- err_ovf  output  1  sticky: push attempted while full.
- err_udf  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - out_flags=RESET_VAL, depth=0, empty=1, full=0, err_ovf=0, err_udf=0.
  - Stack storage cleared to 0.
- Write (wr_en=1, pop=0): on the next edge, out_flags[i] <= wr_mask[i] ? in_flags[i] : out_flags[i]. Latency 1 cycle.
  - wr_mask=0 is a no-op.
  - fwd_flags shows the merged value in the same cycle.
- Push (push=1, pop=0, !full):
  - stack[depth] <= out_flags (the pre-write value, even if wr_en=1 this cycle); depth++.
  - A concurrent write still updates out_flags.
- Pop (pop=1, push=0, !empty):
  - out_flags <= stack[depth-1]; depth--.
  - A concurrent wr_en is discarded; pop has priority over write.
- push=1 and pop=1 in the same cycle:
  - No stack operation, no error.
  - A write, if present, proceeds normally.
- Push while full: stack and depth unchanged, err_ovf <= 1, write proceeds.
- Pop while empty:
  - out_flags and depth unchanged, err_udf <= 1.
  - A concurrent write proceeds (pop is treated as absent).
- Error bits are sticky until clr_err=1.
  - clr_err clears on the next edge.
  - If a new error occurs in the same cycle as clr_err, the bit is set (set wins).
- full, empty and depth are registered-state decodes and change only at edges.
- Stack wrap-around is not permitted; depth saturates at 0 and DEPTH.

Test Plan:
- Reset then wr_en=1, wr_mask=4'b0110, in_flags=4'b1111 -> fwd_flags=4'b0110 the same cycle; out_flags=4'b0110 after the edge. Then wr_mask=4'b1000, in_flags=4'b0000 -> out_flags stays 4'b0110.
- out_flags=4'b0110; push with wr_en=1, mask=4'b1111, in=4'b1001 -> out_flags=4'b1001, depth=1. Then pop with wr_en=1, in=4'b0000 -> out_flags=4'b0110, depth=0, empty=1.
- Four pushes of 4'b0001, 4'b0010, 4'b0100, 4'b1000 -> full=1. Fifth push -> depth=4, err_ovf=1. Four pops restore 4'b1000, 4'b0100, 4'b0010, 4'b0001 in order (LIFO).
- Pop while empty with wr_en=1, mask=4'b1111, in=4'b0011 -> err_udf=1, out_flags=4'b0011, depth=0. clr_err=1 -> err_udf=0 next cycle.
- depth=2, push=1 and pop=1 together -> depth=2, out_flags unchanged, no error bits set.
- depth=3 with err_ovf=1; assert reset asynchronously between edges -> out_flags=RESET_VAL, depth=0, err_ovf=0 immediately, without waiting for a clock edge.
